// File: rtl/unidade_controle_comparacao.sv
// Comparison-sequence control unit: drives the datapath counter and
// chaves register and reports whether a match was found before rco.
module unidade_controle_comparacao (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       registra,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] db_passos,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        REGISTRA   = 4'h2,
        COMPARACAO = 4'h3,
        PROXIMO    = 4'h4,
        ACERTO     = 4'hA,
        ERRO       = 4'hE
    } estado_t;

    estado_t estado;
    estado_t prox;

    // Next-state selection; igual wins over fim in comparacao
    always_comb begin
        prox = INICIAL;
        case (estado)
            INICIAL:    prox = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: prox = REGISTRA;
            REGISTRA:   prox = COMPARACAO;
            COMPARACAO: begin
                if (igual)
                    prox = ACERTO;
                else if (fim)
                    prox = ERRO;
                else
                    prox = PROXIMO;
            end
            PROXIMO:    prox = COMPARACAO;
            ACERTO:     prox = iniciar ? PREPARACAO : ACERTO;
            ERRO:       prox = iniciar ? PREPARACAO : ERRO;
            default:    prox = INICIAL;
        endcase
    end

    // State register with outputs registered from the next state,
    // so every output is a pure function of the current state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= INICIAL;
            zera      <= 1'b0;
            registra  <= 1'b0;
            conta     <= 1'b0;
            pronto    <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            db_estado <= 4'h0;
        end else begin
            estado    <= prox;
            zera      <= (prox == PREPARACAO);
            registra  <= (prox == REGISTRA);
            conta     <= (prox == PROXIMO);
            pronto    <= (prox == ACERTO) || (prox == ERRO);
            acertou   <= (prox == ACERTO);
            errou     <= (prox == ERRO);
            db_estado <= prox;
        end
    end

    // Step counter: cleared entering preparacao, bumped leaving proximo,
    // saturating at 15
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_passos <= 4'h0;
        end else if (prox == PREPARACAO) begin
            db_passos <= 4'h0;
        end else if (estado == PROXIMO && db_passos != 4'hF) begin
            db_passos <= db_passos + 4'h1;
        end
    end

endmodule

// File: tb/tb_unidade_controle_comparacao.sv
// Directed bench for unidade_controle_comparacao: walks through match,
// terminal count, simultaneous events, async reset and restart.
module tb_unidade_controle_comparacao;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       igual;
    logic       fim;
    logic       zera;
    logic       registra;
    logic       conta;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic [3:0] db_passos;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int n_zera = 0;
    int n_reg = 0;
    int n_conta = 0;
    int base_z;
    int base_r;
    int base_c;

    unidade_controle_comparacao dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .igual    (igual),
        .fim      (fim),
        .zera     (zera),
        .registra (registra),
        .conta    (conta),
        .pronto   (pronto),
        .acertou  (acertou),
        .errou    (errou),
        .db_passos(db_passos),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle
    always @(negedge clock) begin
        if (zera)     n_zera++;
        if (registra) n_reg++;
        if (conta)    n_conta++;
    end

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic snap();
        base_z = n_zera;
        base_r = n_reg;
        base_c = n_conta;
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        igual   = 1'b0;
        fim     = 1'b0;
        #1;
        chk("rst_estado", db_estado, 4'h0);
        chk("rst_passos", db_passos, 4'h0);
        chk("rst_outs", {zera, registra, conta, pronto}, 4'h0);
        chk("rst_res", {2'b00, acertou, errou}, 4'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_hold", db_estado, 4'h0);

        // Immediate match
        snap();
        iniciar = 1'b1;
        igual   = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("m0_prep", db_estado, 4'h1);
        chk("m0_zera", {3'b000, zera}, 4'h1);
        tick();
        chk("m0_reg", db_estado, 4'h2);
        chk("m0_registra", {3'b000, registra}, 4'h1);
        chk("m0_zera_off", {3'b000, zera}, 4'h0);
        tick();
        chk("m0_comp", db_estado, 4'h3);
        tick();
        chk("m0_estado", db_estado, 4'hA);
        chk("m0_flags", {acertou, pronto, errou, conta}, 4'b1100);
        chk("m0_passos", db_passos, 4'h0);
        chk("m0_nconta", 4'(n_conta - base_c), 4'h0);
        chk("m0_nzera", 4'(n_zera - base_z), 4'h1);
        chk("m0_nreg", 4'(n_reg - base_r), 4'h1);
        tick();
        chk("m0_hold", db_estado, 4'hA);

        // Match after 3 steps
        snap();
        igual   = 1'b0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("m3_prep", db_estado, 4'h1);
        chk("m3_pclr", db_passos, 4'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("m3_comp", db_estado, 4'h3);
            chk("m3_conta_lo", {3'b000, conta}, 4'h0);
            tick();
            chk("m3_prox", db_estado, 4'h4);
            chk("m3_conta_hi", {3'b000, conta}, 4'h1);
        end
        tick();
        chk("m3_comp4", db_estado, 4'h3);
        chk("m3_passos_mid", db_passos, 4'h3);
        igual = 1'b1;
        tick();
        chk("m3_estado", db_estado, 4'hA);
        chk("m3_acertou", {3'b000, acertou}, 4'h1);
        chk("m3_passos", db_passos, 4'h3);
        chk("m3_nconta", 4'(n_conta - base_c), 4'h3);

        // Terminal count, with an igual glitch between edges
        snap();
        igual   = 1'b0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick();
        chk("tc_comp1", db_estado, 4'h3);
        igual = 1'b1;
        #1;
        igual = 1'b0;
        tick();
        chk("tc_glitch", db_estado, 4'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        tick();
        chk("tc_comp5", db_estado, 4'h3);
        fim = 1'b1;
        tick();
        fim = 1'b0;
        chk("tc_estado", db_estado, 4'hE);
        chk("tc_flags", {errou, acertou, pronto, conta}, 4'b1010);
        chk("tc_passos", db_passos, 4'h4);
        chk("tc_nconta", 4'(n_conta - base_c), 4'h4);
        tick();
        chk("tc_hold", db_estado, 4'hE);
        chk("tc_hold_p", db_passos, 4'h4);

        // Restart from erro with iniciar held, then simultaneous events
        iniciar = 1'b1;
        tick();
        chk("rs_prep", db_estado, 4'h1);
        chk("rs_pclr", db_passos, 4'h0);
        tick();
        chk("rs_reg", db_estado, 4'h2);
        tick();
        chk("rs_comp", db_estado, 4'h3);
        tick();
        chk("rs_prox", db_estado, 4'h4);
        tick();
        chk("rs_comp2", db_estado, 4'h3);
        igual = 1'b1;
        fim   = 1'b1;
        tick();
        chk("sim_estado", db_estado, 4'hA);
        chk("sim_flags", {acertou, errou, pronto, 1'b0}, 4'b1010);
        chk("sim_passos", db_passos, 4'h1);
        igual = 1'b0;
        fim   = 1'b0;
        tick();
        iniciar = 1'b0;
        chk("rs_again", db_estado, 4'h1);

        // Async reset while in proximo
        tick();
        tick();
        tick();
        chk("ar_prox", db_estado, 4'h4);
        chk("ar_conta", {3'b000, conta}, 4'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_estado", db_estado, 4'h0);
        chk("ar_conta0", {3'b000, conta}, 4'h0);
        chk("ar_passos", db_passos, 4'h0);
        #1;
        reset = 1'b0;
        snap();
        repeat (5) tick();
        chk("ar_idle", db_estado, 4'h0);
        chk("ar_npulse",
            4'((n_zera - base_z) + (n_reg - base_r) + (n_conta - base_c)),
            4'h0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("ar_start", db_estado, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
